// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Default 640x480@60 Hz VGA timing constants and derived
//                totals / sync window bounds shared by the raster generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Coordinate width; both totals must fit in this many bits.
    localparam int COORD_W = 10;

    // Default raster timing (pixels / lines) at a 25 MHz pixel rate.
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Derived totals and sync windows (sync is active for START <= x < END).
    localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_counter
//  Description : Enabled up-counter 0..MAX that wraps to 0; reset wins over en.
//                at_max flags the terminal count so callers can chain wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_max = (count_q == c_MAX);
    assign count  = count_q;

    // Next count: advance on enable, wrapping to zero after the terminal value.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset taking priority over enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. A clock divider produces the
//                pixel strobe, chained wrap counters produce col/row, and the
//                syncs, blank and once-per-frame vblank tick are decoded
//                combinationally from the registered coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               clock,
    input  logic               reset,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               HS,
    output logic               VS,
    output logic               blank,
    output logic               pix_en,
    output logic               vblank_tick
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // A divide-by-one divider still needs a 1-bit counter that sits at zero.
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [COORD_W-1:0] c_H_VIS      = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] c_V_VIS      = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] c_V_LAST_VIS = COORD_W'(V_VISIBLE - 1);
    localparam logic [COORD_W-1:0] c_HS_START   = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] c_HS_END     = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] c_VS_START   = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] c_VS_END     = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Reject timings whose totals cannot be represented by the coordinates.
    if ((c_H_TOTAL > 1024) || (c_V_TOTAL > 1024)) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic               w_div_at_max;
    logic               w_col_at_max;
    logic               w_row_en;
    logic               w_unused_row_at_max;
    logic [c_DIV_W-1:0] w_unused_div_count;

    // Pixel strobe: last divider phase, suppressed while reset is held.
    assign pix_en   = w_div_at_max && !reset;
    assign w_row_en = pix_en && w_col_at_max;

    wrap_counter #(
        .WIDTH (c_DIV_W),
        .MAX   (CLK_DIV - 1)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .en     (1'b1),
        .count  (w_unused_div_count),
        .at_max (w_div_at_max)
    );

    wrap_counter #(
        .WIDTH (COORD_W),
        .MAX   (c_H_TOTAL - 1)
    ) u_col (
        .clock  (clock),
        .reset  (reset),
        .en     (pix_en),
        .count  (col),
        .at_max (w_col_at_max)
    );

    wrap_counter #(
        .WIDTH (COORD_W),
        .MAX   (c_V_TOTAL - 1)
    ) u_row (
        .clock  (clock),
        .reset  (reset),
        .en     (w_row_en),
        .count  (row),
        .at_max (w_unused_row_at_max)
    );

    // Sync/blank/tick decode straight from the registered coordinates, so they
    // line up with col/row with no extra pipeline stage.
    always_comb begin
        HS          = !((col >= c_HS_START) && (col < c_HS_END));
        VS          = !((row >= c_VS_START) && (row < c_VS_END));
        blank       = (col >= c_H_VIS) || (row >= c_V_VIS);
        vblank_tick = w_row_en && (row == c_V_LAST_VIS);
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Scoreboard bench for vga_timing_gen. Three instances share
//                clock/reset: A = defaults, B = short vertical frame
//                (4/2/2/3 lines), C = short vertical frame with CLK_DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int        dut;
        string     name;
        int        col;
        int        row;
        bit        hs;
        bit        vs;
        bit        bl;
        bit        pe;
        bit        vt;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] col_a, row_a, col_b, row_b, col_c, row_c;
    logic       hs_a, vs_a, bl_a, pe_a, vt_a;
    logic       hs_b, vs_b, bl_b, pe_b, vt_b;
    logic       hs_c, vs_c, bl_c, pe_c, vt_c;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   base  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    vga_timing_gen u_dut_a (
        .clock(clock), .reset(reset), .col(col_a), .row(row_a), .HS(hs_a),
        .VS(vs_a), .blank(bl_a), .pix_en(pe_a), .vblank_tick(vt_a)
    );

    vga_timing_gen #(
        .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_dut_b (
        .clock(clock), .reset(reset), .col(col_b), .row(row_b), .HS(hs_b),
        .VS(vs_b), .blank(bl_b), .pix_en(pe_b), .vblank_tick(vt_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_dut_c (
        .clock(clock), .reset(reset), .col(col_c), .row(row_c), .HS(hs_c),
        .VS(vs_c), .blank(bl_c), .pix_en(pe_c), .vblank_tick(vt_c)
    );

    task automatic push(input int d, input string nm, input int c, input int r,
                        input bit hs, input bit vs, input bit bl, input bit pe, input bit vt);
        exp_t e;
        e.dut = d; e.name = nm; e.col = c; e.row = r;
        e.hs = hs; e.vs = vs; e.bl = bl; e.pe = pe; e.vt = vt;
        sb.push_back(e);
    endtask

    // Advance to sample point n clocks after the last reset release.
    task automatic goto(input int n);
        while ((cyc - base) < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: pop and compare every expectation at the falling edge.
    initial begin : monitor
        int last_b = -1;
        int last_c = -1;
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                exp_t e;
                int   c, r;
                bit   hs, vs, bl, pe, vt;
                e = sb.pop_front();
                case (e.dut)
                    0: begin c = col_a; r = row_a; hs = hs_a; vs = vs_a; bl = bl_a; pe = pe_a; vt = vt_a; end
                    1: begin c = col_b; r = row_b; hs = hs_b; vs = vs_b; bl = bl_b; pe = pe_b; vt = vt_b; end
                    default: begin c = col_c; r = row_c; hs = hs_c; vs = vs_c; bl = bl_c; pe = pe_c; vt = vt_c; end
                endcase
                n_vec++;
                if (c != e.col || r != e.row || hs != e.hs || vs != e.vs ||
                    bl != e.bl || pe != e.pe || vt != e.vt) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: got col=%0d row=%0d HS=%b VS=%b blank=%b pix_en=%b tick=%b, want col=%0d row=%0d HS=%b VS=%b blank=%b pix_en=%b tick=%b",
                             e.name, e.dut, c, r, hs, vs, bl, pe, vt,
                             e.col, e.row, e.hs, e.vs, e.bl, e.pe, e.vt);
                end
            end
            // Frame period between consecutive vblank ticks.
            if (reset) begin
                last_b = -1;
                last_c = -1;
            end else begin
                if (vt_b) begin
                    if (last_b >= 0) begin
                        n_vec++;
                        if (cyc - last_b != 17600) begin
                            n_bad++;
                            $display("FAIL period_b: got %0d clocks, want 17600", cyc - last_b);
                        end
                    end
                    last_b = cyc;
                end
                if (vt_c) begin
                    if (last_c >= 0) begin
                        n_vec++;
                        if (cyc - last_c != 8800) begin
                            n_bad++;
                            $display("FAIL period_c: got %0d clocks, want 8800", cyc - last_c);
                        end
                    end
                    last_c = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed checkpoints with hand-computed expectations.
    initial begin : stimulus
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        push(0, "in_reset_a", 0, 0, 1, 1, 0, 0, 0);
        push(1, "in_reset_b", 0, 0, 1, 1, 0, 0, 0);
        push(2, "in_reset_c", 0, 0, 1, 1, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        base  = cyc;

        goto(0);    push(0, "rel_a",    0, 0, 1, 1, 0, 0, 0);
                    push(2, "rel_c",    0, 0, 1, 1, 0, 1, 0);
        goto(1);    push(0, "pe1_a",    0, 0, 1, 1, 0, 1, 0);
                    push(2, "col1_c",   1, 0, 1, 1, 0, 1, 0);
        goto(2);    push(0, "pe2_a",    1, 0, 1, 1, 0, 0, 0);
        goto(3);    push(0, "pe3_a",    1, 0, 1, 1, 0, 1, 0);
        goto(4);    push(0, "pe4_a",    2, 0, 1, 1, 0, 0, 0);
        goto(639);  push(2, "vis_c",  639, 0, 1, 1, 0, 1, 0);
        goto(640);  push(2, "blk_c",  640, 0, 1, 1, 1, 1, 0);
        goto(655);  push(2, "hs_pre_c", 655, 0, 1, 1, 1, 1, 0);
        goto(656);  push(2, "hs_on_c",  656, 0, 0, 1, 1, 1, 0);
        goto(751);  push(2, "hs_end_c", 751, 0, 0, 1, 1, 1, 0);
        goto(752);  push(2, "hs_off_c", 752, 0, 1, 1, 1, 1, 0);
        goto(1279); push(0, "vis_a",  639, 0, 1, 1, 0, 1, 0);
        goto(1280); push(0, "blk_a",  640, 0, 1, 1, 1, 0, 0);
        goto(1311); push(0, "hs_pre_a", 655, 0, 1, 1, 1, 1, 0);
        goto(1312); push(0, "hs_on_a",  656, 0, 0, 1, 1, 0, 0);
        goto(1503); push(0, "hs_end_a", 751, 0, 0, 1, 1, 1, 0);
        goto(1504); push(0, "hs_off_a", 752, 0, 1, 1, 1, 0, 0);
        goto(1599); push(0, "eol_a",  799, 0, 1, 1, 1, 1, 0);
        goto(1600); push(0, "wrap_a",   0, 1, 1, 1, 0, 0, 0);
        goto(3199); push(2, "tick_c", 799, 3, 1, 1, 1, 1, 1);
        goto(3200); push(2, "vbl_c",    0, 4, 1, 1, 1, 1, 0);
        goto(6399); push(0, "notick_a", 799, 3, 1, 1, 1, 1, 0);
                    push(1, "tick_b", 799, 3, 1, 1, 1, 1, 1);
        goto(6400); push(1, "vbl_b",    0, 4, 1, 1, 1, 0, 0);
        goto(9599); push(1, "vs_pre_b", 799, 5, 1, 1, 1, 1, 0);
        goto(9600); push(1, "vs_on_b",  0, 6, 1, 0, 1, 0, 0);
        goto(12799); push(1, "vs_end_b", 799, 7, 1, 0, 1, 1, 0);
        goto(12800); push(1, "vs_off_b", 0, 8, 1, 1, 1, 0, 0);
        goto(17599); push(1, "eof_b",  799, 10, 1, 1, 1, 1, 0);
        goto(17600); push(1, "fwrap_b",  0, 0, 1, 1, 0, 0, 0);
        goto(23999); push(1, "tick2_b", 799, 3, 1, 1, 1, 1, 1);

        // Mid-frame reset on a pixel-strobe phase: strobe must be masked.
        goto(32825);
        reset = 1'b1;
        push(1, "rst_hold_b", 412, 9, 1, 1, 1, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        base  = cyc;
        push(0, "rst_rel_a", 0, 0, 1, 1, 0, 0, 0);
        push(1, "rst_rel_b", 0, 0, 1, 1, 0, 0, 0);
        push(2, "rst_rel_c", 0, 0, 1, 1, 0, 1, 0);
        goto(1);    push(1, "rst_pe_b", 0, 0, 1, 1, 0, 1, 0);
        goto(2);    push(1, "rst_col_b", 1, 0, 1, 1, 0, 0, 0);

        @(negedge clock);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
